// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: default fill byte, default RX
// FIFO depth, bit counter sizing and the two-state frame FSM encoding.
package spi_target_pkg;

    localparam logic [7:0] FILL_DEFAULT     = 8'hFF;
    localparam int         RX_DEPTH_DEFAULT = 4;

    // The bit counter must hold 0..8, so four bits are enough.
    localparam int                     BIT_COUNT_W   = 4;
    localparam logic [BIT_COUNT_W-1:0] BITS_PER_BYTE = 4'd8;
    localparam logic [BIT_COUNT_W-1:0] LAST_BIT      = 4'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spiState_t;

endpackage

// File: rtl/spi_target_if.sv
// Bus bundle between the SPI target and its surroundings: the raw SPI pins
// plus the RX stream, the TX holding-register handshake and status flags.
// Names carry the direction as seen from the target (i_ = into the target).
interface spi_target_if;

    logic       i_ss;
    logic       i_sclk;
    logic       i_mosi;
    logic       o_miso;
    logic       o_miso_oe;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_int;
    logic       o_ovf;
    logic       i_ovf_clr;
    logic       o_frame_err;

    modport slave (
        input  i_ss, i_sclk, i_mosi, i_rx_ready, i_tx_data, i_tx_valid, i_ovf_clr,
        output o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_int,
               o_ovf, o_frame_err
    );

    modport master (
        output i_ss, i_sclk, i_mosi, i_rx_ready, i_tx_data, i_tx_valid, i_ovf_clr,
        input  o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_int,
               o_ovf, o_frame_err
    );

endinterface

// File: rtl/spi_target_rxfifo.sv
// Small valid/ready FIFO holding received bytes. Only built when
// SPI_TARGET_RXFIFO_EN is defined; otherwise the target uses a single
// RX register. DEPTH must be a power of two (pointers wrap naturally).
`ifdef SPI_TARGET_RXFIFO_EN
module spi_target_rxfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_write;
    logic             w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rdPtr];
    assign w_write = i_push & ~o_full;
    assign w_pop   = o_valid & i_ready;

    // Storage, pointers and occupancy; a push and a pop may share a cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr] <= i_push_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`endif

// File: rtl/spi_target.sv
// SPI target (mode 0, MSB first, 8-bit frames). SS/SCLK/MOSI are
// oversampled in the system clock domain; received bytes leave on a
// valid/ready stream and transmit bytes come from a one-entry holding
// register. Optional feature macro: SPI_TARGET_RXFIFO_EN replaces the
// single RX register with an RX_DEPTH-entry FIFO.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] FILL = FILL_DEFAULT
`ifdef SPI_TARGET_RXFIFO_EN
    ,
    parameter int RX_DEPTH = RX_DEPTH_DEFAULT
`endif
) (
    input logic         i_clk,
    input logic         i_reset,
    spi_target_if.slave bus
);

    logic r_ssSync1, r_ssSync2, r_ssSync3;
    logic r_sclkSync1, r_sclkSync2, r_sclkSync3;
    logic r_mosiSync1, r_mosiSync2;
    logic w_ssFall, w_ssRise, w_sclkRise, w_sclkFall;

    spiState_t              r_state;
    spiState_t              w_stateNext;
    logic [BIT_COUNT_W-1:0] r_bitCount;
    logic [6:0]             r_rxShift;
    logic [7:0]             r_txShift;
    logic                   r_holdFull;
    logic [7:0]             r_holdData;
    logic                   r_ovf;
    logic                   r_frameErr;

    logic       w_loadByte;
    logic       w_shiftRx;
    logic       w_shiftTx;
    logic       w_pushRx;
    logic       w_leaveFrame;
    logic       w_frameErrSet;
    logic       w_rxDrop;
    logic       w_txWrite;
    logic [7:0] w_loadValue;
    logic [7:0] w_rxByte;

    // Two-flop synchronizers plus a third stage on SS/SCLK for edge detection;
    // reset parks them at the idle bus levels so no edge is seen on release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ssSync1   <= 1'b1;
            r_ssSync2   <= 1'b1;
            r_ssSync3   <= 1'b1;
            r_sclkSync1 <= 1'b0;
            r_sclkSync2 <= 1'b0;
            r_sclkSync3 <= 1'b0;
            r_mosiSync1 <= 1'b0;
            r_mosiSync2 <= 1'b0;
        end else begin
            r_ssSync1   <= bus.i_ss;
            r_ssSync2   <= r_ssSync1;
            r_ssSync3   <= r_ssSync2;
            r_sclkSync1 <= bus.i_sclk;
            r_sclkSync2 <= r_sclkSync1;
            r_sclkSync3 <= r_sclkSync2;
            r_mosiSync1 <= bus.i_mosi;
            r_mosiSync2 <= r_mosiSync1;
        end
    end

    assign w_ssFall   = ~r_ssSync2 & r_ssSync3;
    assign w_ssRise   = r_ssSync2 & ~r_ssSync3;
    assign w_sclkRise = r_sclkSync2 & ~r_sclkSync3;
    assign w_sclkFall = ~r_sclkSync2 & r_sclkSync3;

    // A byte start takes the holding register if it is full, else the fill byte.
    assign w_loadValue = r_holdFull ? r_holdData : FILL;
    assign w_rxByte    = {r_rxShift, r_mosiSync2};
    assign w_txWrite   = bus.i_tx_valid & ~r_holdFull;

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and per-cycle datapath strobes; SS rise outranks SCLK edges.
    always_comb begin
        w_stateNext   = r_state;
        w_loadByte    = 1'b0;
        w_shiftRx     = 1'b0;
        w_shiftTx     = 1'b0;
        w_pushRx      = 1'b0;
        w_leaveFrame  = 1'b0;
        w_frameErrSet = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ssFall) begin
                    w_stateNext = ST_SHIFT;
                    w_loadByte  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ssRise) begin
                    w_stateNext   = ST_IDLE;
                    w_leaveFrame  = 1'b1;
                    w_frameErrSet = (r_bitCount != '0) && (r_bitCount != BITS_PER_BYTE);
                end else if (w_sclkRise && (r_bitCount != BITS_PER_BYTE)) begin
                    w_shiftRx = 1'b1;
                    w_pushRx  = (r_bitCount == LAST_BIT);
                end else if (w_sclkFall) begin
                    if (r_bitCount == BITS_PER_BYTE) begin
                        w_loadByte = 1'b1;
                    end else begin
                        w_shiftTx = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Bit counter and shift registers; MISO is always bit 7 of the TX shifter.
    // The RX shifter keeps only seven bits: the eighth arrives with the push.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bitCount <= '0;
            r_rxShift  <= '0;
            r_txShift  <= '0;
        end else if (w_leaveFrame) begin
            r_bitCount <= '0;
        end else if (w_loadByte) begin
            r_bitCount <= '0;
            r_txShift  <= w_loadValue;
        end else if (w_shiftRx) begin
            r_bitCount <= r_bitCount + 4'd1;
            r_rxShift  <= {r_rxShift[5:0], r_mosiSync2};
        end else if (w_shiftTx) begin
            r_txShift  <= {r_txShift[6:0], 1'b0};
        end
    end

    // TX holding register: a byte-start load empties it, which also blocks a
    // same-cycle write because TX_READY was low while it was full.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_holdFull <= 1'b0;
            r_holdData <= '0;
        end else if (w_loadByte && r_holdFull) begin
            r_holdFull <= 1'b0;
        end else if (w_txWrite) begin
            r_holdFull <= 1'b1;
            r_holdData <= bus.i_tx_data;
        end
    end

`ifdef SPI_TARGET_RXFIFO_EN
    logic       w_rxFull;
    logic [7:0] w_fifoData;
    logic       w_fifoValid;

    assign w_rxDrop = w_pushRx & w_rxFull;

    spi_target_rxfifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rxFifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_pushRx & ~w_rxFull),
        .i_push_data (w_rxByte),
        .o_full      (w_rxFull),
        .o_data      (w_fifoData),
        .o_valid     (w_fifoValid),
        .i_ready     (bus.i_rx_ready)
    );

    assign bus.o_rx_data  = w_fifoData;
    assign bus.o_rx_valid = w_fifoValid;
`else
    logic [7:0] r_rxData;
    logic       r_rxValid;

    // A new byte is dropped only if the previous one is still unclaimed.
    assign w_rxDrop = w_pushRx & r_rxValid & ~bus.i_rx_ready;

    // Single RX register; accept and push in one cycle replaces the byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
        end else if (w_pushRx && !w_rxDrop) begin
            r_rxData  <= w_rxByte;
            r_rxValid <= 1'b1;
        end else if (r_rxValid && bus.i_rx_ready) begin
            r_rxValid <= 1'b0;
        end
    end

    assign bus.o_rx_data  = r_rxData;
    assign bus.o_rx_valid = r_rxValid;
`endif

    // Sticky overflow flag (set beats clear) and the one-cycle frame error pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf      <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= w_frameErrSet;
            if (w_rxDrop) begin
                r_ovf <= 1'b1;
            end else if (bus.i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.o_miso      = r_txShift[7];
    assign bus.o_miso_oe   = (r_state == ST_SHIFT);
    assign bus.o_tx_ready  = ~r_holdFull;
    assign bus.o_int       = r_holdFull;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_frame_err = r_frameErr;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a behavioural SPI master drives frames, and a
// byte-level model (holding register flag, queue of expected RX bytes,
// overflow flag, frame error count) predicts what the target must do.
module tb_spi_target;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    spi_target_if busIf ();

    spi_target dut (
        .i_clk   (clock),
        .i_reset (reset),
        .bus     (busIf.slave)
    );

`ifdef SPI_TARGET_RXFIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    bit         modelHoldFull = 1'b0;
    logic [7:0] modelHoldData = 8'h00;
    logic [7:0] rxQueue[$];
    bit         modelOvf = 1'b0;
    int         frameErrPulses = 0;
    int         expFrameErr = 0;

    logic [7:0] frameMosi[4];
    bit         frameRefill[4];
    logic [7:0] frameRefillVal[4];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Model of a byte start: take the holding byte if present, else 8'hFF.
    task automatic modelLoad(output logic [7:0] value);
        value = modelHoldFull ? modelHoldData : 8'hFF;
        modelHoldFull = 1'b0;
    endtask

    task automatic rxModelPush(input logic [7:0] value);
        if (rxQueue.size() >= RX_CAP) begin
            modelOvf = 1'b1;
        end else begin
            rxQueue.push_back(value);
        end
    endtask

    // Offer a byte to the holding register for one cycle.
    task automatic writeHolding(input logic [7:0] value);
        checkOutput("tx_ready_before_write", 32'(busIf.o_tx_ready), 32'(!modelHoldFull));
        busIf.i_tx_data  = value;
        busIf.i_tx_valid = 1'b1;
        tick(1);
        busIf.i_tx_valid = 1'b0;
        if (!modelHoldFull) begin
            modelHoldFull = 1'b1;
            modelHoldData = value;
        end
        checkOutput("int_after_write", 32'(busIf.o_int), 32'(modelHoldFull));
    endtask

    // Clock nBits of one byte (MSB first) and capture MISO before each rise.
    task automatic spiByte(input logic [7:0] mosiByte, input int half, input int nBits,
                           input bit refill, input logic [7:0] refillVal,
                           output logic [7:0] misoByte);
        misoByte = 8'h00;
        for (int i = 7; i >= 8 - nBits; i--) begin
            busIf.i_mosi = mosiByte[i];
            tick(half);
            misoByte[i] = busIf.o_miso;
            checkOutput("miso_oe_active", 32'(busIf.o_miso_oe), 32'(1));
            if (nBits == 8 && i == 0) begin
                rxModelPush(mosiByte);
            end
            busIf.i_sclk = 1'b1;
            tick(half);
            if (refill && i == 7) begin
                writeHolding(refillVal);
            end
            busIf.i_sclk = 1'b0;
        end
    endtask

    // One SS frame of nBytes; a nonzero lastBits truncates the final byte.
    task automatic applyStimulus(input int nBytes, input int half, input int lastBits);
        logic [7:0] expTx;
        logic [7:0] gotTx;
        int         bits;
        busIf.i_ss = 1'b0;
        modelLoad(expTx);
        tick(4);
        checkOutput("int_after_load", 32'(busIf.o_int), 32'(modelHoldFull));
        for (int b = 0; b < nBytes; b++) begin
            bits = (b == nBytes - 1 && lastBits != 0) ? lastBits : 8;
            spiByte(frameMosi[b], half, bits, frameRefill[b], frameRefillVal[b], gotTx);
            if (bits == 8) begin
                checkOutput("miso_byte", 32'(gotTx), 32'(expTx));
                modelLoad(expTx);
            end else begin
                expFrameErr++;
            end
        end
        tick(half);
        busIf.i_ss = 1'b1;
        tick(6);
        checkOutput("miso_oe_idle", 32'(busIf.o_miso_oe), 32'(0));
        checkOutput("frame_err_count", 32'(frameErrPulses), 32'(expFrameErr));
        checkOutput("rx_valid", 32'(busIf.o_rx_valid), 32'(rxQueue.size() != 0));
        checkOutput("ovf", 32'(busIf.o_ovf), 32'(modelOvf));
        checkOutput("tx_ready", 32'(busIf.o_tx_ready), 32'(!modelHoldFull));
        checkOutput("int", 32'(busIf.o_int), 32'(modelHoldFull));
    endtask

    task automatic setFrame(input int idx, input logic [7:0] mosi, input bit refill, input logic [7:0] refillVal);
        frameMosi[idx]      = mosi;
        frameRefill[idx]    = refill;
        frameRefillVal[idx] = refillVal;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_miso"},      32'(busIf.o_miso),      32'(0));
        checkOutput({tag, "_miso_oe"},   32'(busIf.o_miso_oe),   32'(0));
        checkOutput({tag, "_rx_valid"},  32'(busIf.o_rx_valid),  32'(0));
        checkOutput({tag, "_rx_data"},   32'(busIf.o_rx_data),   32'(0));
        checkOutput({tag, "_tx_ready"},  32'(busIf.o_tx_ready),  32'(1));
        checkOutput({tag, "_int"},       32'(busIf.o_int),       32'(0));
        checkOutput({tag, "_ovf"},       32'(busIf.o_ovf),       32'(0));
        checkOutput({tag, "_frame_err"}, 32'(busIf.o_frame_err), 32'(0));
    endtask

    // RX consumer and frame error counter, sampled on the inactive edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (busIf.o_frame_err) begin
                frameErrPulses++;
            end
            if (busIf.o_rx_valid && busIf.i_rx_ready) begin
                if (rxQueue.size() == 0) begin
                    checkOutput("rx_unexpected", 32'(busIf.o_rx_valid), 32'(0));
                end else begin
                    checkOutput("rx_data", 32'(busIf.o_rx_data), 32'(rxQueue.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] scratch;
        int         nBytes;
        int         lastBits;

        reset            = 1'b1;
        busIf.i_ss       = 1'b1;
        busIf.i_sclk     = 1'b0;
        busIf.i_mosi     = 1'b0;
        busIf.i_rx_ready = 1'b1;
        busIf.i_tx_data  = 8'h00;
        busIf.i_tx_valid = 1'b0;
        busIf.i_ovf_clr  = 1'b0;
        tick(3);
        checkResetValues("por");
        reset = 1'b0;
        tick(3);

        $display("[TB] loaded byte out, 3C in");
        writeHolding(8'hA5);
        setFrame(0, 8'h3C, 1'b0, 8'h00);
        applyStimulus(1, 8, 0);

        $display("[TB] empty holding sends fill");
        setFrame(0, 8'h00, 1'b0, 8'h00);
        applyStimulus(1, 8, 0);

        $display("[TB] back-to-back bytes with refill");
        setFrame(0, 8'h11, 1'b1, 8'h5A);
        setFrame(1, 8'h22, 1'b0, 8'h00);
        applyStimulus(2, 6, 0);

        $display("[TB] partial frame then clean frame");
        setFrame(0, 8'h99, 1'b0, 8'h00);
        applyStimulus(1, 5, 5);
        setFrame(0, 8'hC3, 1'b0, 8'h00);
        applyStimulus(1, 5, 0);

        $display("[TB] overflow with consumer stalled");
        busIf.i_rx_ready = 1'b0;
        for (int b = 0; b <= RX_CAP; b++) begin
            setFrame(b, 8'(8'h40 + b), 1'b0, 8'h00);
        end
        applyStimulus(RX_CAP + 1, 4, 0);
        busIf.i_rx_ready = 1'b1;
        tick(RX_CAP + 4);
        checkOutput("rx_drained", 32'(rxQueue.size()), 32'(0));
        checkOutput("ovf_held", 32'(busIf.o_ovf), 32'(modelOvf));
        busIf.i_ovf_clr = 1'b1;
        tick(1);
        busIf.i_ovf_clr = 1'b0;
        modelOvf = 1'b0;
        checkOutput("ovf_cleared", 32'(busIf.o_ovf), 32'(0));

        $display("[TB] reset in the middle of a byte");
        writeHolding(8'hA5);
        busIf.i_ss = 1'b0;
        modelLoad(scratch);
        tick(5);
        writeHolding(8'h5A);
        spiByte(8'hF0, 5, 3, 1'b0, 8'h00, scratch);
        reset = 1'b1;
        tick(1);
        checkResetValues("mid_reset");
        busIf.i_ss   = 1'b1;
        busIf.i_sclk = 1'b0;
        tick(4);
        reset = 1'b0;
        modelHoldFull = 1'b0;
        rxQueue.delete();
        modelOvf = 1'b0;
        tick(4);
        checkOutput("no_frame_err_on_reset", 32'(frameErrPulses), 32'(expFrameErr));
        setFrame(0, 8'h6E, 1'b0, 8'h00);
        applyStimulus(1, 4, 0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(1, 0) == 1) begin
                writeHolding(8'($urandom));
            end
            nBytes = $urandom_range(3, 1);
            for (int b = 0; b < nBytes; b++) begin
                setFrame(b, 8'($urandom), 1'($urandom_range(1, 0)), 8'($urandom));
            end
            lastBits = ($urandom_range(6, 0) == 0) ? $urandom_range(7, 1) : 0;
            applyStimulus(nBytes, $urandom_range(7, 4), lastBits);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder (slave) for the card's serial link: the receiving end of the FPGA's SPI master, used as the on-board peer model and in the loopback test build. It oversamples SS/SCLK/MOSI in the CLK domain (mode 0, MSB first, 8-bit frames). Received bytes go to a valid/ready stream and transmit bytes come from a one-entry holding register. INT tells the peer when a TX byte is loaded.

## Interface
- FILL, 8'hFF, byte shifted out on MISO when the TX holding register is empty at byte start
- RX_DEPTH, 4, RX FIFO depth (power of two; used only with SPI_TARGET_RXFIFO_EN)
- CLK  in  1  system clock (52 MHz)
- RESET  in  1  synchronous, active-high reset
- SS  in  1  chip select, active low, asynchronous to CLK
- SCLK  in  1  serial clock, idle low, asynchronous
- MOSI  in  1  serial data in, asynchronous
- MISO  out  1  serial data out
- MISO_OE  out  1  MISO drive enable (high while synced SS low)
- RX_DATA  out  8  received byte
- RX_VALID  out  1  RX_DATA valid
- RX_READY  in  1  consumer accepts RX byte when RX_VALID&RX_READY
- TX_DATA  in  8  byte to send
- TX_VALID  in  1  TX_DATA offered
- TX_READY  out  1  holding register empty; write on TX_VALID&TX_READY
- INT  out  1  high when holding register full (peer may clock a byte)
- OVF  out  1  sticky: RX byte dropped
- OVF_CLR  in  1  clears OVF
- FRAME_ERR  out  1  one-cycle pulse: SS rose with 1..7 bits shifted

## Operation
- Two-flop synchronizers on SS, SCLK, MOSI. A third SCLK/SS flop gives the edge detection: rise = s2&~s3, fall = ~s2&s3.
- States: IDLE, SHIFT.
- IDLE: MISO_OE=0, bit count 0. On SS fall -> SHIFT. Load TX shift from holding (holding emptied, TX_READY=1 next cycle) or FILL. MISO = bit 7.
- SHIFT, SCLK rise: rx_shift = {rx_shift[6:0], MOSI_s}, count+1.
- SHIFT, SCLK rise, count becomes 8: push {rx_shift[6:0],MOSI_s} to RX. If RX full: drop, set OVF.
- SHIFT, SCLK fall, count<8: tx_shift <<= 1, MISO = new bit 7.
- SHIFT, SCLK fall, count==8: reload from holding/FILL, count=0 (back-to-back bytes).
- SS rise: -> IDLE. Count 1..7: discard partial byte, pulse FRAME_ERR. A byte reloaded but not yet clocked is lost (not returned to holding).
- Holding write and byte-start load in the same cycle: the load takes the old content; the write is refused (TX_READY was high only if empty; if empty, the load uses FILL and the write lands).
- OVF set and OVF_CLR in the same cycle: set wins.
- RESET: state IDLE, MISO=0, MISO_OE=0, RX empty (RX_VALID=0, RX_DATA=0), holding empty (TX_READY=1, INT=0), OVF=0, FRAME_ERR=0, count 0. Reset mid-frame aborts without FRAME_ERR.

## Timing
- Input-to-internal latency: 2 CLK (synchronizers) + 1 (edge detect).
- Required SCLK high and low time ≥ 4 CLK. SS fall to first SCLK rise ≥ 4 CLK.
- MISO changes 3 CLK after the physical SCLK fall / SS fall.
- RX_VALID rises 1 CLK after the 8th detected rise. RX_DATA is stable while RX_VALID && !RX_READY.
- TX_READY/INT update the CLK after the handshake/load.

## Configuration
- SPI_TARGET_RXFIFO_EN defined: RX path is a RX_DEPTH-entry FIFO. OVF is set only when the FIFO is full at the push.
- Not defined: single RX register. OVF is set when a byte completes while RX_VALID is still high and not accepted in that cycle. Accepting in the same cycle as a push is allowed.

## Structure
- spi_pkg: FILL default, RX_DEPTH default, state encoding (IDLE, SHIFT), bit-count width.
- Sub-module spi_target_rxfifo: valid/ready FIFO; compiled in only under SPI_TARGET_RXFIFO_EN.

## Test plan
- Load TX_DATA=8'hA5, master sends 8'h3C with SCLK period 16 CLK -> MISO bits 1,0,1,0,0,1,0,1. RX_DATA=8'h3C with RX_VALID. INT 1->0 at SS fall.
- Holding empty, master sends 8'h00 -> MISO all ones (FILL). RX_DATA=8'h00.
- Back-to-back bytes 8'h11, 8'h22 in one SS frame with holding refilled with 8'h5A between -> second byte out is 8'h5A, both RX bytes delivered in order.
- SS raised after 5 bits -> FRAME_ERR one pulse, no RX_VALID, next frame receives 8'hC3 correctly.
- RX_READY=0, send 2 bytes (no FIFO) or RX_DEPTH+1 bytes (FIFO) -> OVF=1, the first bytes are retained and the last is dropped. OVF_CLR -> OVF=0.
- RESET asserted mid-byte -> all outputs take reset values next cycle, no FRAME_ERR, next frame is correct.
